axi_line_ctrl: RTL and testbench

//  AXI4 burst controller for one cache block: a line fill (AR/R burst) or a writeback (AW/W/B burst).

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_line_ctrl.sv | 156 +++++++++++++++
 tb/tb_axi_line_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the line controller.
//   t_line_state   : burst controller FSM state encoding
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : xRESP encoding for a clean response
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_LOAD = 3'd3,
    ST_AW   = 3'd4,
    ST_W    = 3'd5,
    ST_B    = 3'd6,
    ST_DONE = 3'd7
  } t_line_state;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_line_ctrl.sv
// AXI4 burst controller for one cache block. It runs either a line fill
// (AR + R burst) or a writeback (FIFO load, AW + W burst, B). It is
// control-only: R data goes straight into the block shift FIFO, and W data
// comes straight out of it. This block only sequences load/shift.
// Ports:
//   i_clk, i_arst          clock, async active-high reset
//   i_rd_req / i_wr_req    level requests, held until o_done (write wins)
//   i_addr                 block address, offset bits ignored
//   o_busy, o_done, o_error  status (error is sticky until next request)
//   o_fifo_load/o_fifo_shift FIFO parallel capture / per-beat shift
//   AR, R, AW, W, B        AXI4 master channel controls (no data)
module axi_line_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic                        i_rd_req,
  input  logic                        i_wr_req,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_fifo_load,
  output logic                        o_fifo_shift,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  output logic [ADDR_WIDTH-1:0]       o_araddr,
  output logic [7:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  input  logic                        i_rvalid,
  output logic                        o_rready,
  input  logic                        i_rlast,
  input  logic [1:0]                  i_rresp,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  output logic                        o_wlast,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  input  logic [1:0]                  i_bresp
);

  localparam int BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(BLOCK_WIDTH / 8);
  localparam int SIZE   = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  t_line_state             state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   blk_addr;
  logic                    r_hs;
  logic                    w_hs;
  logic                    last_beat;

  assign blk_addr  = i_addr & ~OFF_MASK;
  assign r_hs      = (state == ST_R) && i_rvalid;
  assign w_hs      = (state == ST_W) && i_wready;
  assign last_beat = (cnt == LAST_CNT);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (i_wr_req) begin
            state  <= ST_LOAD;
            addr_q <= blk_addr;
            err_q  <= 1'b0;
          end else if (i_rd_req) begin
            state  <= ST_AR;
            addr_q <= blk_addr;
            err_q  <= 1'b0;
          end
        end
        ST_AR: if (i_arready) state <= ST_R;
        ST_R: begin
          if (r_hs) begin
            cnt <= cnt + 1'b1;
            if (i_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            // rlast must coincide with the final beat; either side of a
            // mismatch is an error and terminates the burst here.
            if (i_rlast != last_beat) err_q <= 1'b1;
            if (i_rlast || last_beat) begin
              cnt   <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: state <= ST_AW;
        ST_AW:   if (i_awready) state <= ST_W;
        ST_W: begin
          if (w_hs) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= ST_B;
          end
        end
        ST_B: begin
          if (i_bvalid) begin
            if (i_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valids and readies decode purely from state so reset drops them
  // asynchronously; payloads come from the address captured at accept.
  assign o_busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done       = (state == ST_DONE);
  assign o_error      = err_q;
  assign o_fifo_load  = (state == ST_LOAD);
  assign o_fifo_shift = r_hs || w_hs;

  assign o_arvalid    = (state == ST_AR);
  assign o_araddr     = addr_q;
  assign o_arlen      = 8'(BEATS - 1);
  assign o_arsize     = 3'(SIZE);
  assign o_arburst    = AXI_BURST_INCR;
  assign o_rready     = (state == ST_R);

  assign o_awvalid    = (state == ST_AW);
  assign o_awaddr     = addr_q;
  assign o_awlen      = 8'(BEATS - 1);
  assign o_awsize     = 3'(SIZE);
  assign o_awburst    = AXI_BURST_INCR;
  assign o_wvalid     = (state == ST_W);
  assign o_wlast      = (state == ST_W) && last_beat;
  assign o_wstrb      = '1;
  assign o_bready     = (state == ST_B);

endmodule

// File: tb/tb_axi_line_ctrl.sv
// Directed bench for axi_line_ctrl: a table of transactions against a
// configurable slave responder, plus hand sequences for priority, reset
// mid-burst and error clearing.
module tb_axi_line_ctrl;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_rd_req, i_wr_req;
  logic [31:0] i_addr;
  logic        o_busy, o_done, o_error, o_fifo_load, o_fifo_shift;
  logic        o_arvalid, i_arready;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic        i_rvalid, o_rready, i_rlast;
  logic [1:0]  i_rresp;
  logic        o_awvalid, i_awready;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic        o_wvalid, i_wready, o_wlast;
  logic [3:0]  o_wstrb;
  logic        i_bvalid, o_bready;
  logic [1:0]  i_bresp;

  always #5 i_clk = ~i_clk;

  axi_line_ctrl dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_rd_req(i_rd_req), .i_wr_req(i_wr_req),
    .i_addr(i_addr), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_fifo_load(o_fifo_load), .o_fifo_shift(o_fifo_shift),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rlast(i_rlast), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wlast(o_wlast), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // slave configuration
  int       cfg_ar_wait, cfg_aw_wait, cfg_rlast_beat, cfg_badr_beat;
  bit       cfg_wtog;
  logic [1:0] cfg_bresp;

  // monitors
  int  m_shift, m_load, m_rbeat, m_wbeat, m_wlast_bad, m_stall_shift;
  int  m_unstable, m_busy_bad, m_const_bad, m_cyc, m_b_cyc, m_done_cyc;
  int  ar_wait_cnt, aw_wait_cnt;
  bit  m_ar_seen, m_aw_seen, m_first, wtog;
  logic [31:0] m_araddr, m_awaddr, m_word0, rdata;

  task automatic set_cfg(input int arw, input int aww, input int rl, input int br,
                         input bit wt, input logic [1:0] bresp);
    cfg_ar_wait = arw; cfg_aw_wait = aww; cfg_rlast_beat = rl;
    cfg_badr_beat = br; cfg_wtog = wt; cfg_bresp = bresp;
  endtask

  task automatic mon_clear();
    m_shift = 0; m_load = 0; m_rbeat = 0; m_wbeat = 0; m_wlast_bad = 0;
    m_stall_shift = 0; m_unstable = 0; m_busy_bad = 0; m_const_bad = 0;
    m_b_cyc = -100; m_done_cyc = 0; ar_wait_cnt = 0; aw_wait_cnt = 0;
    m_ar_seen = 0; m_aw_seen = 0; m_first = 1; m_araddr = '0; m_awaddr = '0;
    m_word0 = 32'hFFFF_FFFF;
  endtask

  // Slave responder and monitor: inputs driven on the falling edge,
  // combinational outputs sampled 1 time unit later.
  always @(negedge i_clk) begin
    if (i_arst) begin
      i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rresp = 0;
      i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    end else begin
      i_arready = o_arvalid && (ar_wait_cnt >= cfg_ar_wait);
      if (o_arvalid && !i_arready) ar_wait_cnt++;
      i_awready = o_awvalid && (aw_wait_cnt >= cfg_aw_wait);
      if (o_awvalid && !i_awready) aw_wait_cnt++;
      i_rvalid  = o_rready;
      i_rlast   = o_rready && (m_rbeat == cfg_rlast_beat);
      i_rresp   = (o_rready && m_rbeat == cfg_badr_beat) ? 2'b10 : 2'b00;
      rdata     = i_rvalid ? 32'(m_rbeat) : 32'hDEAD_BEEF;
      wtog      = ~wtog;
      i_wready  = o_wvalid && (!cfg_wtog || wtog);
      i_bvalid  = o_bready;
      i_bresp   = cfg_bresp;
      #1;
      m_cyc++;
      if (o_fifo_shift) begin
        m_shift++;
        if (m_first) begin m_word0 = rdata; m_first = 0; end
      end
      if (o_rready && i_rvalid) m_rbeat++;
      if (o_wvalid && i_wready) begin
        if (o_wlast != (m_wbeat == 15)) m_wlast_bad++;
        m_wbeat++;
      end
      if (o_arvalid) begin
        if (!m_ar_seen) m_araddr = o_araddr;
        else if (o_araddr != m_araddr) m_unstable++;
        m_ar_seen = 1;
        if (o_arlen != 8'd15 || o_arsize != 3'd2 || o_arburst != 2'b01) m_const_bad++;
        if (o_fifo_shift) m_stall_shift++;
        if (!o_busy) m_busy_bad++;
      end
      if (o_awvalid) begin
        if (!m_aw_seen) m_awaddr = o_awaddr;
        else if (o_awaddr != m_awaddr) m_unstable++;
        m_aw_seen = 1;
        if (o_awlen != 8'd15 || o_awsize != 3'd2 || o_awburst != 2'b01 || o_wstrb != 4'hF)
          m_const_bad++;
        if (o_fifo_shift || o_wvalid) m_stall_shift++;
        if (!o_busy) m_busy_bad++;
      end
      if (o_fifo_load) m_load++;
      if (i_bvalid && o_bready) m_b_cyc = m_cyc;
      if (o_done) m_done_cyc = m_cyc;
    end
  end

  // Raise the request, count rising edges until o_done is seen.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input bit hold_rd, output int lat);
    @(negedge i_clk);
    mon_clear();
    i_addr = addr; i_rd_req = rd; i_wr_req = wr;
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      #2;
      if (c == 1) chk("error_clear_on_accept", o_error, 0);
      if (o_done) begin lat = c; break; end
    end
    i_wr_req = 0;
    if (!hold_rd) i_rd_req = 0;
    if (lat < 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no o_done within 300 cycles, required done");
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          ar_wait, aw_wait, rlast_beat, badr_beat;
    bit          wtog;
    logic [1:0]  bresp;
    logic [31:0] exp_addr;
    int          exp_shift;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[9];
  int   lat;

  initial begin
    //          wr addr          arw aww rl  br  wt bresp exp_addr       sh err lat
    vt[0] = '{0, 32'h0000_1234,  0,  0, 15, -1, 0, 2'b00, 32'h0000_1200, 16, 0, 18};
    vt[1] = '{1, 32'h8000_0040,  0,  0, 15, -1, 1, 2'b00, 32'h8000_0040, 16, 0, -1};
    vt[2] = '{1, 32'h0000_0FFF,  0,  0, 15, -1, 0, 2'b00, 32'h0000_0FC0, 16, 0, 20};
    vt[3] = '{0, 32'h0000_0000,  0,  0,  9, -1, 0, 2'b00, 32'h0000_0000, 10, 1, 12};
    vt[4] = '{0, 32'hABCD_EF7F,  0,  0, 15,  2, 0, 2'b00, 32'hABCD_EF40, 16, 1, 18};
    vt[5] = '{1, 32'h0000_0100,  0,  0, 15, -1, 0, 2'b10, 32'h0000_0100, 16, 1, 20};
    vt[6] = '{0, 32'h0000_2040, 20,  0, 15, -1, 0, 2'b00, 32'h0000_2040, 16, 0, 38};
    vt[7] = '{1, 32'h0000_3000,  0, 20, 15, -1, 0, 2'b00, 32'h0000_3000, 16, 0, 40};
    vt[8] = '{0, 32'h0000_5000,  0,  0, 99, -1, 0, 2'b00, 32'h0000_5000, 16, 1, 18};

    i_arst = 1; i_rd_req = 0; i_wr_req = 0; i_addr = '0;
    i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rresp = 0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    m_cyc = 0; wtog = 0; rdata = '0;
    set_cfg(0, 0, 15, -1, 0, 2'b00);
    mon_clear();
    #3;
    chk("reset_outputs",
        {26'd0, o_busy, o_done, o_error, o_fifo_load, o_fifo_shift, 1'b0}, 32'd0);
    chk("reset_valids",
        {27'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'd0);
    @(negedge i_clk);
    i_arst = 0;

    for (int i = 0; i < 9; i++) begin
      set_cfg(vt[i].ar_wait, vt[i].aw_wait, vt[i].rlast_beat, vt[i].badr_beat,
              vt[i].wtog, vt[i].bresp);
      run_txn(!vt[i].wr, vt[i].wr, vt[i].addr, 0, lat);
      if (vt[i].exp_lat >= 0) chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_addr", i), vt[i].wr ? m_awaddr : m_araddr, vt[i].exp_addr);
      chk($sformatf("v%0d_shifts", i), m_shift, vt[i].exp_shift);
      chk($sformatf("v%0d_load", i), m_load, vt[i].wr ? 1 : 0);
      chk($sformatf("v%0d_other_chan", i), vt[i].wr ? m_ar_seen : m_aw_seen, 0);
      chk($sformatf("v%0d_consts", i), m_const_bad, 0);
      chk($sformatf("v%0d_stall", i), m_unstable + m_stall_shift + m_busy_bad, 0);
      if (vt[i].wr) begin
        chk($sformatf("v%0d_wlast", i), m_wlast_bad, 0);
        chk($sformatf("v%0d_wbeats", i), m_wbeat, 16);
        chk($sformatf("v%0d_done_after_b", i), m_done_cyc - m_b_cyc, 1);
      end else begin
        chk($sformatf("v%0d_word0", i), m_word0, 0);
      end
      @(negedge i_clk);
      #2;
      chk($sformatf("v%0d_error_sticky", i), o_error, vt[i].exp_err);
      chk($sformatf("v%0d_idle", i), {o_busy, o_done}, 0);
    end

    // Both requests: writeback first, fill follows on the held rd_req.
    set_cfg(0, 0, 15, -1, 0, 2'b00);
    run_txn(1, 1, 32'h0000_6010, 1, lat);
    chk("prio_wb_latency", lat, 20);
    chk("prio_wb_load", m_load, 1);
    chk("prio_wb_no_ar", m_ar_seen, 0);
    chk("prio_wb_awaddr", m_awaddr, 32'h0000_6000);
    run_txn(1, 0, 32'h0000_6010, 0, lat);
    chk("prio_fill_latency", lat, 18);
    chk("prio_fill_araddr", m_araddr, 32'h0000_6000);
    chk("prio_fill_shifts", m_shift, 16);

    // Reset during W beat 7.
    @(negedge i_clk);
    mon_clear();
    i_addr = 32'h0000_4000; i_wr_req = 1;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      #2;
      if (m_wbeat == 6 && o_wvalid) begin lat = c; break; end
    end
    chk("rst_reached_w7", (lat >= 0), 1);
    i_arst = 1;
    #1;
    chk("rst_valids_drop",
        {27'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'd0);
    chk("rst_status", {28'd0, o_busy, o_done, o_fifo_shift, o_fifo_load}, 32'd0);
    i_wr_req = 0;
    @(negedge i_clk);
    i_arst = 0;
    run_txn(1, 0, 32'h0000_1234, 0, lat);
    chk("post_rst_latency", lat, 18);
    chk("post_rst_araddr", m_araddr, 32'h0000_1200);
    chk("post_rst_shifts", m_shift, 16);
    chk("post_rst_no_aw", m_aw_seen, 0);
    @(negedge i_clk);
    #2;
    chk("post_rst_error", o_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
